// File: rtl/maze_pkg.sv
// Shared types and direction helpers for the wall-following maze solver.
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FIND_ENTRY = 3'd1,
    ST_WALK       = 3'd2,
    ST_DONE       = 3'd3,
    ST_FAIL       = 3'd4
  } state_t;

  function automatic dir_t turn_right(input dir_t d);
    return dir_t'(d + 2'd1);
  endfunction

  function automatic dir_t turn_left(input dir_t d);
    return dir_t'(d - 2'd1);
  endfunction

  function automatic dir_t turn_back(input dir_t d);
    return dir_t'(d + 2'd2);
  endfunction

  function automatic logic signed [1:0] dx(input dir_t d);
    case (d)
      DIR_E:   dx = 2'sb01;
      DIR_W:   dx = 2'sb11;
      default: dx = 2'sb00;
    endcase
  endfunction

  function automatic logic signed [1:0] dy(input dir_t d);
    case (d)
      DIR_S:   dy = 2'sb01;
      DIR_N:   dy = 2'sb11;
      default: dy = 2'sb00;
    endcase
  endfunction

  // Candidate i (0..3) in try order; hand=0 favours right turns, hand=1 left turns.
  function automatic dir_t try_dir(input dir_t h, input logic hand, input logic [1:0] i);
    case (i)
      2'd0:    try_dir = hand ? turn_left(h) : turn_right(h);
      2'd1:    try_dir = h;
      2'd2:    try_dir = hand ? turn_right(h) : turn_left(h);
      default: try_dir = turn_back(h);
    endcase
  endfunction

endpackage

// File: rtl/maze_neighbour.sv
// Combinational open-neighbour lookup; cells outside the maze count as walls.
module maze_neighbour
  import maze_pkg::*;
#(
  parameter int SIZE = 21,
  parameter int N    = $clog2(SIZE)
) (
  input  logic [SIZE-1:0][SIZE-1:0] maze,
  input  logic [N-1:0]              px,
  input  logic [N-1:0]              py,
  output logic [3:0]                open
);

  logic [N:0] nx;
  logic [N:0] ny;

  // One extra bit lets a step to -1 wrap far above SIZE, so a single compare bounds both sides.
  always_comb begin
    open = 4'b0000;
    nx   = '0;
    ny   = '0;
    for (int d = 0; d < 4; d++) begin
      nx = {1'b0, px} + (N+1)'(dx(dir_t'(2'(d))));
      ny = {1'b0, py} + (N+1)'(dy(dir_t'(2'(d))));
      if ((nx < (N+1)'(SIZE)) && (ny < (N+1)'(SIZE))) begin
        open[d] = ~maze[ny[N-1:0]][nx[N-1:0]];
      end else begin
        open[d] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/maze_wall_follower.sv
// Wall-following maze solver: scans row 0 for an entry, then walks one move
// per cycle until the bottom row is reached or the step budget runs out.
module maze_wall_follower
  import maze_pkg::*;
#(
  parameter int SIZE      = 21,
  parameter int N         = $clog2(SIZE),
  parameter int MAX_STEPS = 4*SIZE*SIZE,
  parameter int SW        = $clog2(MAX_STEPS+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SIZE-1:0][SIZE-1:0] maze,
  input  logic                      start,
  input  logic                      hand,
  output logic [N-1:0]              px,
  output logic [N-1:0]              py,
  output logic                      busy,
  output logic                      done,
  output logic                      fail,
  output logic [SW-1:0]             steps,
  output logic [SIZE-1:0][SIZE-1:0] path
);

  localparam logic [N-1:0]  LAST   = N'(SIZE-1);
  localparam logic [SW-1:0] BUDGET = SW'(MAX_STEPS);

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  cnt;
  dir_t          heading;
  logic          hand_l;
  logic [3:0]    open;
  logic          found;
  dir_t          move_dir;
  logic [N-1:0]  nx_move;
  logic [N-1:0]  ny_move;
  logic [SW-1:0] steps_inc;

  maze_neighbour #(.SIZE(SIZE), .N(N)) u_neighbour (
    .maze (maze),
    .px   (px),
    .py   (py),
    .open (open)
  );

  // Pick the first open neighbour in the hand-dependent try order.
  always_comb begin
    found    = 1'b0;
    move_dir = heading;
    for (int i = 0; i < 4; i++) begin
      if (!found && open[try_dir(heading, hand_l, 2'(i))]) begin
        found    = 1'b1;
        move_dir = try_dir(heading, hand_l, 2'(i));
      end else begin
        found    = found;
      end
    end
    nx_move   = px + N'(dx(move_dir));
    ny_move   = py + N'(dy(move_dir));
    steps_inc = steps + SW'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; reaching the bottom row wins over an exhausted budget.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) state_next = ST_FIND_ENTRY;
        else       state_next = state;
      end
      ST_FIND_ENTRY: begin
        if (!maze[0][cnt])     state_next = ST_WALK;
        else if (cnt == LAST)  state_next = ST_FAIL;
        else                   state_next = state;
      end
      ST_WALK: begin
        if (found && (ny_move == LAST)) state_next = ST_DONE;
        else if (steps_inc == BUDGET)   state_next = ST_FAIL;
        else                            state_next = state;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: coordinates, heading, path map, step counter and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      px      <= '0;
      py      <= '0;
      cnt     <= '0;
      heading <= DIR_S;
      hand_l  <= 1'b0;
      steps   <= '0;
      path    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            path   <= '0;
            steps  <= '0;
            cnt    <= '0;
            hand_l <= hand;
          end
        end
        ST_FIND_ENTRY: begin
          if (!maze[0][cnt]) begin
            px           <= cnt;
            py           <= '0;
            heading      <= DIR_S;
            path[0][cnt] <= 1'b1;
          end else begin
            cnt <= cnt + N'(1);
          end
        end
        ST_WALK: begin
          steps <= steps_inc;
          if (found) begin
            px                     <= nx_move;
            py                     <= ny_move;
            heading                <= move_dir;
            path[ny_move][nx_move] <= 1'b1;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
      busy <= (state_next == ST_FIND_ENTRY) || (state_next == ST_WALK);
      done <= (state_next == ST_DONE);
      fail <= (state_next == ST_FAIL);
    end
  end

endmodule
